iir_biquad_mc: RTL and testbench

Parametrised successor to the first-order iir1 filter: a second-order (biquad, direct form I) IIR with programmable Q-format coefficients, time-multiplexed across NCH independent channels. It uses a 2-stage pipeline with valid/ready input, a per-channel coefficient/config write port, and selectable saturate or wrap output. It sits between the sample source and downstream DSP; with b2=a2=0 it implements a first-order section.

---
 rtl/iir_pkg.sv | 40 ++++
 rtl/iir_shift_sat.sv | 31 +++
 rtl/iir_biquad_mc.sv | 154 +++++++++++++++
 tb/tb_iir_biquad_mc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared constants and range helper for the biquad IIR filter
// Coefficient slot indices, the widest intermediate result width, and
// sat_or_wrap(), which range-checks a full-precision result against an
// OUT_W-bit signed output and either clamps it or leaves it for wrapping.
package iir_pkg;

   localparam int COEF_B0 = 0;
   localparam int COEF_B1 = 1;
   localparam int COEF_B2 = 2;
   localparam int COEF_A1 = 3;
   localparam int COEF_A2 = 4;
   localparam int NCOEF   = 5;

   // Widest shifted accumulator the helper accepts
   localparam int Y_MAX_W = 64;

   typedef struct packed {
      logic               ovf;
      logic [Y_MAX_W-1:0] value;
   } sat_res_t;

   // value holds the clamped result when sat_en is set; otherwise it is
   // y_full untouched and the caller keeps the low out_w bits (wrap).
   function automatic sat_res_t sat_or_wrap(input logic signed [Y_MAX_W-1:0] y_full,
                                            input logic                      sat_en,
                                            input int                        out_w);
      logic signed [Y_MAX_W-1:0] hi;
      logic signed [Y_MAX_W-1:0] lo;
      sat_res_t                  r;
      hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo      = ~hi;
      r.ovf   = (y_full > hi) || (y_full < lo);
      r.value = y_full;
      if (sat_en && r.ovf) begin
         r.value = (y_full > hi) ? hi : lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/iir_shift_sat.sv
// rtl/iir_shift_sat.sv - Q-format rescale plus saturate/wrap of an accumulator
// Ports:
//   acc    in  ACC_W  signed full-precision accumulator
//   sat_en in  1      1 = clamp to the OUT_W range, 0 = two's-complement wrap
//   y      out OUT_W  rescaled, range-limited result
//   ovf    out 1      rescaled result did not fit in OUT_W bits
module iir_shift_sat
   import iir_pkg::*;
#(
   parameter int ACC_W     = 27,
   parameter int COEF_FRAC = 6,
   parameter int OUT_W     = 16
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic                    sat_en,
   output logic signed [OUT_W-1:0] y,
   output logic                    ovf
);

   logic signed [ACC_W-1:0] y_full;
   sat_res_t                res;

   always_comb begin
      // Arithmetic shift floors toward minus infinity
      y_full = acc >>> COEF_FRAC;
      res    = sat_or_wrap(Y_MAX_W'(y_full), sat_en, OUT_W);
      y      = OUT_W'(res.value);
      ovf    = res.ovf;
   end

endmodule

// File: rtl/iir_biquad_mc.sv
// rtl/iir_biquad_mc.sv - multichannel direct-form-I biquad IIR, 2-stage pipeline
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           sample handshake; in_ch selects the channel,
//                               in_data is the signed sample x[n]
//   cfg_we/cfg_ch/cfg_idx/cfg_data   coefficient write (0=b0 1=b1 2=b2 3=a1 4=a2)
//   sat_en                      1 = saturate, 0 = wrap the output
//   clr_we/clr_ch               zero the history of one channel
//   out_valid/out_ch/out_data/out_ovf   one-cycle result strobe and result
module iir_biquad_mc
   import iir_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 8,
   parameter int COEF_FRAC = 6,
   parameter int OUT_W     = 16,
   parameter int NCH       = 4,
   parameter int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     cfg_we,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic [2:0]               cfg_idx,
   input  logic signed [COEF_W-1:0] cfg_data,
   input  logic                     sat_en,
   input  logic                     clr_we,
   input  logic [CH_W-1:0]          clr_ch,
   output logic                     out_valid,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_ovf
);

   localparam int              ACC_W = OUT_W + COEF_W + 3;
   localparam logic [CH_W:0]   NCH_L = (CH_W + 1)'(NCH);

   // Per-channel coefficients and history
   logic signed [COEF_W-1:0] coef [NCH][NCOEF];
   logic signed [DATA_W-1:0] x1 [NCH];
   logic signed [DATA_W-1:0] x2 [NCH];
   logic signed [OUT_W-1:0]  y1 [NCH];
   logic signed [OUT_W-1:0]  y2 [NCH];

   // Stage 1 registers
   logic                     s1_valid;
   logic [CH_W-1:0]          s1_ch;
   logic signed [DATA_W-1:0] s1_x;
   logic signed [ACC_W-1:0]  s1_p [NCOEF];

   logic                     in_ok, cfg_ok, clr_ok, accept;
   logic [CH_W-1:0]          rd_ch;
   logic signed [ACC_W-1:0]  prod [NCOEF];
   logic signed [ACC_W-1:0]  acc;
   logic signed [OUT_W-1:0]  y_res;
   logic                     y_ovf;

   assign in_ok  = {1'b0, in_ch}  < NCH_L;
   assign cfg_ok = {1'b0, cfg_ch} < NCH_L;
   assign clr_ok = {1'b0, clr_ch} < NCH_L;

   // A channel sitting in stage 1 has not written its history back yet, so a
   // second sample for it must wait one cycle. Out-of-range channels are
   // never in stage 1 and are therefore always accepted, then dropped.
   assign in_ready = !rst && !(s1_valid && s1_ch == in_ch);
   assign accept   = in_valid && in_ready && in_ok;
   assign rd_ch    = in_ok ? in_ch : '0;

   // Operands are widened to ACC_W first so each product is full precision
   always_comb begin
      prod[COEF_B0] = ACC_W'(coef[rd_ch][COEF_B0]) * ACC_W'(in_data);
      prod[COEF_B1] = ACC_W'(coef[rd_ch][COEF_B1]) * ACC_W'(x1[rd_ch]);
      prod[COEF_B2] = ACC_W'(coef[rd_ch][COEF_B2]) * ACC_W'(x2[rd_ch]);
      prod[COEF_A1] = ACC_W'(coef[rd_ch][COEF_A1]) * ACC_W'(y1[rd_ch]);
      prod[COEF_A2] = ACC_W'(coef[rd_ch][COEF_A2]) * ACC_W'(y2[rd_ch]);
   end

   // Feedback terms are added; callers negate a1/a2 for the textbook form
   assign acc = s1_p[COEF_B0] + s1_p[COEF_B1] + s1_p[COEF_B2]
              + s1_p[COEF_A1] + s1_p[COEF_A2];

   iir_shift_sat #(
      .ACC_W     (ACC_W),
      .COEF_FRAC (COEF_FRAC),
      .OUT_W     (OUT_W)
   ) u_shift_sat (
      .acc    (acc),
      .sat_en (sat_en),
      .y      (y_res),
      .ovf    (y_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            for (int k = 0; k < NCOEF; k++) begin
               coef[c][k] <= '0;
            end
            x1[c] <= '0;
            x2[c] <= '0;
            y1[c] <= '0;
            y2[c] <= '0;
         end
         for (int k = 0; k < NCOEF; k++) begin
            s1_p[k] <= '0;
         end
         s1_valid  <= 1'b0;
         s1_ch     <= '0;
         s1_x      <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_ovf   <= 1'b0;
      end else begin
         // Stage 1 has already sampled the old coefficient on this edge
         if (cfg_we && cfg_ok && cfg_idx < 3'(NCOEF)) begin
            coef[cfg_ch][cfg_idx] <= cfg_data;
         end

         s1_valid <= accept;
         if (accept) begin
            s1_ch <= in_ch;
            s1_x  <= in_data;
            for (int k = 0; k < NCOEF; k++) begin
               s1_p[k] <= prod[k];
            end
         end

         out_valid <= s1_valid;
         if (s1_valid) begin
            out_ch          <= s1_ch;
            out_data        <= y_res;
            out_ovf         <= y_ovf;
            x2[s1_ch]       <= x1[s1_ch];
            x1[s1_ch]       <= s1_x;
            y2[s1_ch]       <= y1[s1_ch];
            y1[s1_ch]       <= y_res;
         end

         // Placed last so a clear overrides a same-edge history update
         if (clr_we && clr_ok) begin
            x1[clr_ch] <= '0;
            x2[clr_ch] <= '0;
            y1[clr_ch] <= '0;
            y2[clr_ch] <= '0;
         end
      end
   end

endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb/tb_iir_biquad_mc.sv - directed self-checking bench for iir_biquad_mc
module tb_iir_biquad_mc;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         in_ch;
   logic signed [7:0]  in_data;
   logic               cfg_we;
   logic [1:0]         cfg_ch;
   logic [2:0]         cfg_idx;
   logic signed [7:0]  cfg_data;
   logic               sat_en;
   logic               clr_we;
   logic [1:0]         clr_ch;
   logic               out_valid;
   logic [1:0]         out_ch;
   logic signed [15:0] out_data;
   logic               out_ovf;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int ch;
      int x;
      bit sat;
      bit clr;
      int y;
      bit ovf;
   } vec_t;

   vec_t vecs [31];

   int rr_ch [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int rr_x  [8] = '{5, 64, 1, 127, -7, 0, 2, 127};
   int rr_y  [8] = '{5, 64, 1, 252, -7, 32, 3, 752};

   iir_biquad_mc dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .cfg_we    (cfg_we),
      .cfg_ch    (cfg_ch),
      .cfg_idx   (cfg_idx),
      .cfg_data  (cfg_data),
      .sat_en    (sat_en),
      .clr_we    (clr_we),
      .clr_ch    (clr_ch),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int ch, input int idx, input int val);
      cfg_we   = 1'b1;
      cfg_ch   = 2'(ch);
      cfg_idx  = 3'(idx);
      cfg_data = 8'(val);
      tick();
      cfg_we   = 1'b0;
   endtask

   task automatic clear(input int ch);
      clr_we = 1'b1;
      clr_ch = 2'(ch);
      tick();
      clr_we = 1'b0;
   endtask

   // One isolated sample: accept, check the stall and the empty output
   // slot, then check the result one edge later.
   task automatic send(input int id, input int ch, input int x, input bit sat,
                       input int y, input bit ovf);
      in_valid = 1'b1;
      in_ch    = 2'(ch);
      in_data  = 8'(x);
      sat_en   = sat;
      #1;
      chk($sformatf("v%0d ready", id), in_ready, 1);
      tick();
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d stall", id), in_ready, 0);
      chk($sformatf("v%0d early", id), out_valid, 0);
      tick();
      chk($sformatf("v%0d valid", id), out_valid, 1);
      chk($sformatf("v%0d ch", id), out_ch, ch);
      chk($sformatf("v%0d data", id), out_data, y);
      chk($sformatf("v%0d ovf", id), out_ovf, ovf);
   endtask

   initial begin
      // ch0 passthrough, ch1 decay, ch2 FIR sum, ch3 growth to saturation
      vecs[0]  = '{0, 5,   1'b1, 1'b0, 5,   1'b0};
      vecs[1]  = '{0, -7,  1'b1, 1'b0, -7,  1'b0};
      vecs[2]  = '{1, 64,  1'b1, 1'b0, 64,  1'b0};
      vecs[3]  = '{1, 0,   1'b1, 1'b0, 32,  1'b0};
      vecs[4]  = '{1, 0,   1'b1, 1'b0, 16,  1'b0};
      vecs[5]  = '{1, 0,   1'b1, 1'b0, 8,   1'b0};
      vecs[6]  = '{1, 0,   1'b1, 1'b0, 4,   1'b0};
      vecs[7]  = '{1, 0,   1'b1, 1'b0, 2,   1'b0};
      vecs[8]  = '{2, 1,   1'b1, 1'b0, 1,   1'b0};
      vecs[9]  = '{2, 2,   1'b1, 1'b0, 3,   1'b0};
      vecs[10] = '{2, 3,   1'b1, 1'b0, 6,   1'b0};
      vecs[11] = '{2, 0,   1'b1, 1'b0, 5,   1'b0};
      vecs[12] = '{2, 0,   1'b1, 1'b0, 3,   1'b0};
      vecs[13] = '{3, 127, 1'b1, 1'b0, 252,   1'b0};
      vecs[14] = '{3, 127, 1'b1, 1'b0, 752,   1'b0};
      vecs[15] = '{3, 127, 1'b1, 1'b0, 1744,  1'b0};
      vecs[16] = '{3, 127, 1'b1, 1'b0, 3712,  1'b0};
      vecs[17] = '{3, 127, 1'b1, 1'b0, 7618,  1'b0};
      vecs[18] = '{3, 127, 1'b1, 1'b0, 15368, 1'b0};
      vecs[19] = '{3, 127, 1'b1, 1'b0, 30747, 1'b0};
      vecs[20] = '{3, 127, 1'b1, 1'b0, 32767, 1'b1};
      vecs[21] = '{3, 127, 1'b1, 1'b0, 32767, 1'b1};
      vecs[22] = '{3, 127, 1'b0, 1'b1, 252,   1'b0};
      vecs[23] = '{3, 127, 1'b0, 1'b0, 752,   1'b0};
      vecs[24] = '{3, 127, 1'b0, 1'b0, 1744,  1'b0};
      vecs[25] = '{3, 127, 1'b0, 1'b0, 3712,  1'b0};
      vecs[26] = '{3, 127, 1'b0, 1'b0, 7618,  1'b0};
      vecs[27] = '{3, 127, 1'b0, 1'b0, 15368, 1'b0};
      vecs[28] = '{3, 127, 1'b0, 1'b0, 30747, 1'b0};
      vecs[29] = '{3, 127, 1'b0, 1'b0, -4271, 1'b1};
      vecs[30] = '{3, 127, 1'b0, 1'b0, -8224, 1'b0};

      rst      = 1'b1;
      in_valid = 1'b0;
      in_ch    = '0;
      in_data  = '0;
      cfg_we   = 1'b0;
      cfg_ch   = '0;
      cfg_idx  = '0;
      cfg_data = '0;
      sat_en   = 1'b1;
      clr_we   = 1'b0;
      clr_ch   = '0;

      repeat (3) tick();
      chk("rst out_valid", out_valid, 0);
      chk("rst out_data", out_data, 0);
      chk("rst out_ch", out_ch, 0);
      chk("rst out_ovf", out_ovf, 0);
      chk("rst in_ready", in_ready, 0);
      rst = 1'b0;
      #1;
      chk("post-rst in_ready", in_ready, 1);

      cfg(0, 0, 64);
      cfg(1, 0, 64);
      cfg(1, 3, 32);
      cfg(2, 0, 64);
      cfg(2, 1, 64);
      cfg(2, 2, 64);
      cfg(3, 0, 127);
      cfg(3, 3, 127);

      for (int i = 0; i < 31; i++) begin
         if (vecs[i].clr) clear(vecs[i].ch);
         send(i, vecs[i].ch, vecs[i].x, vecs[i].sat, vecs[i].y, vecs[i].ovf);
      end

      // Round-robin, one sample per cycle across all channels
      for (int c = 0; c < 4; c++) clear(c);
      sat_en   = 1'b1;
      in_valid = 1'b1;
      in_ch    = 2'(rr_ch[0]);
      in_data  = 8'(rr_x[0]);
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("rr%0d ready", i), in_ready, 1);
         tick();
         if (i > 0) begin
            chk($sformatf("rr%0d valid", i - 1), out_valid, 1);
            chk($sformatf("rr%0d ch", i - 1), out_ch, rr_ch[i - 1]);
            chk($sformatf("rr%0d data", i - 1), out_data, rr_y[i - 1]);
         end
         if (i < 7) begin
            in_ch   = 2'(rr_ch[i + 1]);
            in_data = 8'(rr_x[i + 1]);
         end else begin
            in_valid = 1'b0;
         end
      end
      tick();
      chk("rr7 valid", out_valid, 1);
      chk("rr7 ch", out_ch, rr_ch[7]);
      chk("rr7 data", out_data, rr_y[7]);
      tick();
      chk("rr drain", out_valid, 0);

      // b0 rewrite on the accept edge: this sample sees 64, the next 32
      in_valid = 1'b1;
      in_ch    = 2'd0;
      in_data  = 8'sd10;
      cfg_we   = 1'b1;
      cfg_ch   = 2'd0;
      cfg_idx  = 3'd0;
      cfg_data = 8'sd32;
      tick();
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      tick();
      chk("cfg-edge valid", out_valid, 1);
      chk("cfg-edge old b0", out_data, 10);
      send(100, 0, 10, 1'b1, 5, 1'b0);

      // Clear colliding with the stage-2 writeback of ch1
      clear(1);
      send(101, 1, 64, 1'b1, 64, 1'b0);
      in_valid = 1'b1;
      in_ch    = 2'd1;
      in_data  = 8'sd0;
      tick();
      in_valid = 1'b0;
      clr_we   = 1'b1;
      clr_ch   = 2'd1;
      tick();
      clr_we   = 1'b0;
      chk("clr in-flight valid", out_valid, 1);
      chk("clr in-flight data", out_data, 32);
      send(102, 1, 8, 1'b1, 8, 1'b0);

      // Reset with both pipeline stages occupied
      in_valid = 1'b1;
      in_ch    = 2'd0;
      in_data  = 8'sd3;
      tick();
      in_ch    = 2'd1;
      tick();
      in_valid = 1'b0;
      chk("full s2 valid", out_valid, 1);
      chk("full s2 data", out_data, 1);
      rst = 1'b1;
      tick();
      chk("mid-rst out_valid", out_valid, 0);
      chk("mid-rst out_data", out_data, 0);
      chk("mid-rst out_ch", out_ch, 0);
      chk("mid-rst out_ovf", out_ovf, 0);
      chk("mid-rst in_ready", in_ready, 0);
      rst = 1'b0;
      tick();
      chk("post-rst no strobe", out_valid, 0);
      tick();
      chk("post-rst no strobe 2", out_valid, 0);
      send(103, 0, 5, 1'b1, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
